// File: rtl/nonce_scheduler.sv
// Nonce scheduler for the SHA-256 mining datapath: issues a nonce range into the
// pipeline, tracks in-flight work and latches the first hash that beats the target.
module nonce_scheduler #(
    parameter int WORD_S       = 32,
    parameter int H_SIZE       = 256,
    parameter int MAX_INFLIGHT = 64,
    parameter int CNT_W        = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_S-1:0] nonce_start,
    input  logic [WORD_S-1:0] nonce_end,
    input  logic [H_SIZE-1:0] target,
    input  logic              issue_ready,
    output logic              issue_valid,
    output logic [WORD_S-1:0] issue_nonce,
    input  logic              res_valid,
    input  logic [WORD_S-1:0] res_nonce,
    input  logic [H_SIZE-1:0] res_hash,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [WORD_S-1:0] found_nonce,
    output logic [H_SIZE-1:0] found_hash,
    output logic [WORD_S-1:0] results_cnt
);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [WORD_S-1:0] cur_q, cur_d;
    logic [WORD_S-1:0] end_q, end_d;
    logic [H_SIZE-1:0] target_q, target_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic              found_q, found_d;
    logic [WORD_S-1:0] found_nonce_q, found_nonce_d;
    logic [H_SIZE-1:0] found_hash_q, found_hash_d;
    logic [WORD_S-1:0] results_cnt_q, results_cnt_d;
    logic              busy_q, busy_d;

    logic accept;
    logic res_take;
    logic hit;

    // abort suppresses the offer itself so the pipeline never sees the nonce
    assign issue_valid = (state_q == StIssue) && (inflight_q < CNT_W'(MAX_INFLIGHT)) && !abort;
    assign issue_nonce = cur_q;
    assign accept      = issue_valid && issue_ready;

    // results only count while a job owns outstanding work
    assign res_take = res_valid && (inflight_q != '0) &&
                      ((state_q == StIssue) || (state_q == StDrain));
    assign hit      = res_take && (res_hash < target_q);

    assign busy        = busy_q;
    assign done        = (state_q == StDone);
    assign found       = found_q;
    assign found_nonce = found_nonce_q;
    assign found_hash  = found_hash_q;
    assign results_cnt = results_cnt_q;

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        end_d         = end_q;
        target_d      = target_q;
        inflight_d    = inflight_q;
        found_d       = found_q;
        found_nonce_d = found_nonce_q;
        found_hash_d  = found_hash_q;
        results_cnt_d = results_cnt_q;

        unique case ({accept, res_take})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        if (res_take) begin
            results_cnt_d = results_cnt_q + WORD_S'(1);
            if (hit && !found_q) begin
                found_d       = 1'b1;
                found_nonce_d = res_nonce;
                found_hash_d  = res_hash;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cur_d         = nonce_start;
                    end_d         = nonce_end;
                    target_d      = target;
                    found_d       = 1'b0;
                    found_nonce_d = '0;
                    found_hash_d  = '0;
                    results_cnt_d = '0;
                    inflight_d    = '0;
                    state_d       = StIssue;
                end
            end
            StIssue: begin
                if (accept) begin
                    cur_d = cur_q + WORD_S'(1);
                end
                if (abort || hit || (accept && (cur_q == end_q))) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (inflight_d == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StIssue) || (state_d == StDrain);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cur_q         <= '0;
            end_q         <= '0;
            target_q      <= '0;
            inflight_q    <= '0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
            results_cnt_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            end_q         <= end_d;
            target_q      <= target_d;
            inflight_q    <= inflight_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
            found_hash_q  <= found_hash_d;
            results_cnt_q <= results_cnt_d;
            busy_q        <= busy_d;
        end
    end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Self-checking bench for nonce_scheduler: table of jobs run against a fixed-latency
// echo pipeline model, with a queue scoreboard for issue order and result accounting.
module tb_nonce_scheduler;

    localparam int WORD_S       = 32;
    localparam int H_SIZE       = 256;
    localparam int MAX_INFLIGHT = 4;
    localparam int CNT_W        = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [WORD_S-1:0] nonce_start;
    logic [WORD_S-1:0] nonce_end;
    logic [H_SIZE-1:0] target;
    logic              issue_ready;
    logic              issue_valid;
    logic [WORD_S-1:0] issue_nonce;
    logic              res_valid;
    logic [WORD_S-1:0] res_nonce;
    logic [H_SIZE-1:0] res_hash;
    logic              busy;
    logic              done;
    logic              found;
    logic [WORD_S-1:0] found_nonce;
    logic [H_SIZE-1:0] found_hash;
    logic [WORD_S-1:0] results_cnt;

    always #5 clk = ~clk;

    nonce_scheduler #(
        .WORD_S      (WORD_S),
        .H_SIZE      (H_SIZE),
        .MAX_INFLIGHT(MAX_INFLIGHT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .nonce_start(nonce_start),
        .nonce_end  (nonce_end),
        .target     (target),
        .issue_ready(issue_ready),
        .issue_valid(issue_valid),
        .issue_nonce(issue_nonce),
        .res_valid  (res_valid),
        .res_nonce  (res_nonce),
        .res_hash   (res_hash),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .found_nonce(found_nonce),
        .found_hash (found_hash),
        .results_cnt(results_cnt)
    );

    typedef struct {
        logic [WORD_S-1:0] ns;
        logic [WORD_S-1:0] ne;
        logic [H_SIZE-1:0] tgt;
        bit                hit_en;
        logic [WORD_S-1:0] hit_n;
        logic [H_SIZE-1:0] hit_h;
        int                lat;
        bit                toggle;
        int                abort_at;
        int                exp_issued;
        bit                exp_found;
        logic [WORD_S-1:0] exp_fn;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [WORD_S-1:0] pipe_n[$];
    int                pipe_due[$];
    logic [WORD_S-1:0] exp_q[$];
    vec_t              vecs[8];

    task automatic chk(input string name, input logic [H_SIZE-1:0] act,
                       input logic [H_SIZE-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Pipeline hash model: the hit nonce returns hit_h, its successor returns 2
    // (a later, also-winning hash), everything else is far above any target used.
    function automatic logic [H_SIZE-1:0] hash_of(input logic [WORD_S-1:0] n, input vec_t v);
        if (v.hit_en && n == v.hit_n) return v.hit_h;
        if (v.hit_en && n == v.hit_n + 32'd1) return 256'd2;
        return {32'hFFFF_FFFF, 192'd0, n};
    endfunction

    function automatic vec_t mk(input logic [WORD_S-1:0] ns, input logic [WORD_S-1:0] ne,
                                input logic [H_SIZE-1:0] tgt, input bit hit_en,
                                input logic [WORD_S-1:0] hit_n, input logic [H_SIZE-1:0] hit_h,
                                input int lat, input bit toggle, input int abort_at,
                                input int exp_issued, input bit exp_found,
                                input logic [WORD_S-1:0] exp_fn);
        vec_t v;
        v.ns = ns; v.ne = ne; v.tgt = tgt; v.hit_en = hit_en; v.hit_n = hit_n;
        v.hit_h = hit_h; v.lat = lat; v.toggle = toggle; v.abort_at = abort_at;
        v.exp_issued = exp_issued; v.exp_found = exp_found; v.exp_fn = exp_fn;
        return v;
    endfunction

    task automatic run_job(input vec_t v, output int results);
        int               issued   = 0;
        int               dones    = 0;
        int               done_cyc = -1;
        int               last_res = -1;
        int               hit_cyc  = -1;
        int               max_out  = 0;
        int               k        = 0;
        logic [WORD_S-1:0] n;
        results = 0;
        exp_q.delete();
        pipe_n.delete();
        pipe_due.delete();
        n = v.ns;
        for (int i = 0; i < 2000; i++) begin
            exp_q.push_back(n);
            if (n == v.ne) break;
            n = n + 32'd1;
        end
        start       = 1'b1;
        nonce_start = v.ns;
        nonce_end   = v.ne;
        target      = v.tgt;
        tick();
        start = 1'b0;
        while (dones == 0 && k < 3000) begin
            abort       = (k == v.abort_at);
            issue_ready = v.toggle ? (k % 2 == 0) : 1'b1;
            if (pipe_n.size() > 0 && pipe_due[0] <= cyc) begin
                res_valid = 1'b1;
                res_nonce = pipe_n.pop_front();
                void'(pipe_due.pop_front());
                res_hash  = hash_of(res_nonce, v);
                results++;
                last_res  = cyc;
                if (hit_cyc < 0 && res_hash < v.tgt) hit_cyc = cyc;
            end else begin
                res_valid = 1'b0;
            end
            #1;
            if (k == 0) begin
                chk("first_issue_valid", issue_valid, 1'b1);
                chk("busy_in_job", busy, 1'b1);
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            if (issue_valid && issue_ready) begin
                issued++;
                if (exp_q.size() == 0) chk("issue_beyond_range", issue_nonce, 0);
                else chk("issue_order", issue_nonce, exp_q.pop_front());
                chk("issue_after_abort", (v.abort_at >= 0 && k >= v.abort_at), 1'b0);
                chk("issue_after_hit", (hit_cyc >= 0 && cyc > hit_cyc), 1'b0);
                pipe_n.push_back(issue_nonce);
                pipe_due.push_back(cyc + v.lat);
            end
            if (issued - results > max_out) max_out = issued - results;
            tick();
            k++;
        end
        abort       = 1'b0;
        issue_ready = 1'b0;
        res_valid   = 1'b0;
        #1;
        chk("done_pulses", dones, 1);
        chk("done_single_cycle", done, 1'b0);
        chk("busy_after_done", busy, 1'b0);
        chk("pipe_drained", pipe_n.size(), 0);
        chk("max_inflight_ok", (max_out > MAX_INFLIGHT), 1'b0);
        chk("results_cnt", results_cnt, results);
        if (results > 0) chk("done_latency", done_cyc, last_res + 1);
        if (v.exp_issued >= 0) begin
            chk("issued_count", issued, v.exp_issued);
            chk("range_fully_issued", exp_q.size(), 0);
        end
        chk("found", found, v.exp_found);
        chk("found_nonce", found_nonce, v.exp_found ? v.exp_fn : 32'd0);
        chk("found_hash", found_hash, v.exp_found ? hash_of(v.exp_fn, v) : 256'd0);
    endtask

    initial begin
        int last_results;
        int accepts;
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        nonce_start = '0;
        nonce_end   = '0;
        target      = '0;
        issue_ready = 1'b0;
        res_valid   = 1'b0;
        res_nonce   = '0;
        res_hash    = '0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst_issue_valid", issue_valid, 1'b0);
        chk("rst_issue_nonce", issue_nonce, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_found", found, 1'b0);
        chk("rst_found_nonce", found_nonce, 0);
        chk("rst_found_hash", found_hash, 0);
        chk("rst_results_cnt", results_cnt, 0);

        //          start         end           target                  hit  hit_n  hit_h
        //          lat tog abort exp_iss found fn
        vecs[0] = mk(32'h10, 32'h13, 256'd0, 0, 0, 0, 4, 0, -1, 4, 0, 0);
        vecs[1] = mk(32'hFFFF_FFFE, 32'h1, 256'd0, 0, 0, 0, 4, 0, -1, 4, 0, 0);
        vecs[2] = mk(32'd0, 32'd99, 256'h10, 1, 32'd37, 256'd1, 4, 0, -1, -1, 1, 32'd37);
        vecs[3] = mk(32'd0, 32'd19, 256'd0, 0, 0, 0, 20, 1, -1, 20, 0, 0);
        vecs[4] = mk(32'd0, 32'd1000, 256'd0, 0, 0, 0, 4, 0, 5, -1, 0, 0);
        vecs[5] = mk(32'h55, 32'h55, 256'd0, 0, 0, 0, 3, 0, -1, 1, 0, 0);
        // hash equal to target is not a hit; the successor's hash 2 is
        vecs[6] = mk(32'd0, 32'd3, 256'h10, 1, 32'd2, 256'h10, 2, 0, -1, 4, 1, 32'd3);
        vecs[7] = mk(32'd0, 32'd3, {1'b1, 255'd0}, 1, 32'd1, {1'b0, {255{1'b1}}},
                     2, 1, -1, -1, 1, 32'd1);

        foreach (vecs[i]) run_job(vecs[i], last_results);

        // spurious results in IDLE leave the last job's count alone
        for (int i = 0; i < 3; i++) begin
            res_valid = 1'b1;
            res_nonce = i;
            res_hash  = 256'd0;
            tick();
        end
        res_valid = 1'b0;
        #1;
        chk("idle_spurious_cnt", results_cnt, last_results);
        chk("idle_spurious_busy", busy, 1'b0);

        // reset while draining three outstanding nonces
        tick();
        start       = 1'b1;
        nonce_start = 32'd0;
        nonce_end   = 32'd2;
        target      = {H_SIZE{1'b1}};
        tick();
        start       = 1'b0;
        issue_ready = 1'b1;
        accepts     = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (issue_valid && issue_ready) accepts++;
            tick();
        end
        issue_ready = 1'b0;
        #1;
        chk("drain_accepts", accepts, 3);
        chk("drain_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_issue_valid", issue_valid, 1'b0);
        chk("mid_rst_issue_nonce", issue_nonce, 0);
        chk("mid_rst_results_cnt", results_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            res_valid = 1'b1;
            res_nonce = i;
            res_hash  = 256'd0;
        end
        tick();
        res_valid = 1'b0;
        #1;
        chk("late_res_cnt", results_cnt, 0);
        chk("late_res_found", found, 1'b0);
        chk("late_res_done", done, 1'b0);
        chk("late_res_busy", busy, 1'b0);

        run_job(vecs[0], last_results);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nonce_scheduler.md
Name: nonce_scheduler

Overview:
- Sequences the SHA-256 mining datapath: issues a nonce range into the compression pipeline and tracks in-flight work.
- Consumes the final-hash-stage results (hash, nonce, valid), compares each hash against a 256-bit target and records the first winning nonce.
- Sits between the host/AXI control registers and the pipeline input / final-hash-add stage.

Parameters:
- WORD_S, 32, nonce/word width in bits
- H_SIZE, 256, hash width in bits
- MAX_INFLIGHT, 64, maximum nonces issued but not yet returned
- CNT_W, 7, in-flight counter width; must hold MAX_INFLIGHT

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a job (accepted in IDLE only)
- abort  in  1  stop issuing; drain outstanding work
- nonce_start  in  WORD_S  first nonce of range
- nonce_end  in  WORD_S  last nonce of range (inclusive)
- target  in  H_SIZE  hit threshold; sampled on accepted start
- issue_ready  in  1  pipeline can accept a nonce this cycle
- issue_valid  out  1  issue_nonce valid this cycle
- issue_nonce  out  WORD_S  nonce presented to pipeline
- res_valid  in  1  result valid (final-hash-stage enable out)
- res_nonce  in  WORD_S  nonce belonging to result
- res_hash  in  H_SIZE  final hash of result
- busy  out  1  high in ISSUE or DRAIN
- done  out  1  one-cycle pulse at job end
- found  out  1  a hit was recorded in the current/last job
- found_nonce  out  WORD_S  nonce of first hit
- found_hash  out  H_SIZE  hash of first hit
- results_cnt  out  WORD_S  results received in current/last job

Behaviour:
- Reset: state IDLE; issue_valid=0, issue_nonce=0, busy=0, done=0, found=0, found_nonce=0, found_hash=0, results_cnt=0, in-flight count=0. Reset mid-job discards everything; results arriving after reset release are ignored until the next start.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - On start, latch nonce_start into cur, latch nonce_end and target.
  - Clear found, found_nonce, found_hash and results_cnt; go to ISSUE.
- ISSUE:
  - issue_valid = (state==ISSUE) && (inflight < MAX_INFLIGHT); combinational, issue_nonce = cur.
  - A nonce is accepted when issue_valid && issue_ready. On accept, cur <= cur+1 (mod 2^WORD_S) and inflight increments.
  - If the accepted nonce == nonce_end, go to DRAIN.
  - abort, or a hit registered this cycle, goes to DRAIN; no further nonces are issued.
  - abort takes priority over an accept in the same cycle: the nonce is not issued.
- Range wrap: if nonce_end < nonce_start, the range runs through 0xFFFFFFFF, wraps to 0 and ends at nonce_end. nonce_end == nonce_start issues exactly one nonce.
- In-flight counter:
  - +1 on accept, -1 on res_valid; unchanged when both happen in the same cycle.
  - res_valid with inflight==0 (spurious, or arriving in IDLE/DONE) is ignored: no underflow, no count, no compare.
- Result handling (ISSUE or DRAIN, inflight>0):
  - results_cnt increments on each res_valid.
  - A hit is res_hash < target, compared as unsigned H_SIZE-bit values with bit H_SIZE-1 as MSB.
  - Only the first hit is latched: found<=1, found_nonce<=res_nonce, found_hash<=res_hash. Later hits are counted but do not overwrite.
- DRAIN: no issue; continue consuming results; go to DONE when inflight==0, including the cycle where the final res_valid brings it to 0.
- DONE: done=1 for exactly one cycle, then IDLE. found, found_nonce, found_hash and results_cnt hold until the next accepted start.
- busy is registered, high in ISSUE and DRAIN.
- start while busy is ignored. start and abort together in IDLE: start wins; abort is sampled from the next cycle.
- Latency: first issue_valid appears the cycle after an accepted start; done follows the last result by 1 cycle.

Test Plan:
- Range 0x10..0x13, issue_ready=1, 4-cycle echo pipeline, target=0 → 4 issues (0x10..0x13), results_cnt=4, found=0, single done pulse.
- Wrap: start=0xFFFFFFFE, end=0x00000001 → issue order FFFFFFFE, FFFFFFFF, 0, 1; results_cnt=4.
- Hit: range 0..99, pipeline returns hash=0x00..01 for nonce 37, target=0x00..10 → issuing stops within 1 cycle of the hit, found_nonce=37, DRAIN returns all outstanding, results_cnt equals issued count.
- Backpressure/limit: MAX_INFLIGHT=4, pipeline holds results 20 cycles, issue_ready toggling 1/0 → never more than 4 outstanding, no nonce skipped or duplicated.
- Abort at cycle 5 of range 0..1000 → no issue after the abort cycle, done only after inflight reaches 0; spurious res_valid in IDLE leaves results_cnt unchanged.
- Reset asserted during DRAIN with 3 outstanding → all outputs 0; late res_valid ignored; next start runs cleanly.
